offload_ingress_queue: RTL and testbench

//  Elastic input queue directly upstream of the Offloaded accelerator; drives its io_in decoupled port.

---
 rtl/offload_ingress_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_offload_ingress_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/offload_ingress_queue.sv
// offload_ingress_queue
//  Elastic FIFO in front of the Offloaded accelerator's io_in port, plus one
//  stage of the perf-counter chain. Answers counter reads addressed to
//  MODULE_ID with in/out transfer and stall counts or current occupancy.
//  Optional feature macro: OFFLOAD_IQ_CLEAR_ON_READ_EN (clear XFER/STALL
//  counters when they are read over the chain).
module offload_ingress_queue #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int MODULE_ID = 1
) (
   input  logic             clk,
   input  logic             reset,
   // upstream
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_bits,
   // downstream (Offloaded io_in)
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_bits,
   // perf-counter chain in
   input  logic             io_pcIn_valid,
   input  logic             io_pcIn_bits_request,
   input  logic [15:0]      io_pcIn_bits_moduleId,
   input  logic [7:0]       io_pcIn_bits_portId,
   input  logic [15:0]      io_pcIn_bits_pcValue,
   input  logic [3:0]       io_pcIn_bits_pcType,
   // perf-counter chain out
   output logic             io_pcOut_valid,
   output logic             io_pcOut_bits_request,
   output logic [15:0]      io_pcOut_bits_moduleId,
   output logic [7:0]       io_pcOut_bits_portId,
   output logic [15:0]      io_pcOut_bits_pcValue,
   output logic [3:0]       io_pcOut_bits_pcType
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [15:0]   MID      = 16'(MODULE_ID);

   // counter slots
   localparam int C_IN_XFER   = 0;
   localparam int C_IN_STALL  = 1;
   localparam int C_OUT_XFER  = 2;
   localparam int C_OUT_STALL = 3;

   // ---------------------------------------------------------------
   // Queue storage and control
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             in_fire, out_fire;

   assign io_in_ready  = in_ready_q;
   assign io_out_valid = (count_q != '0);
   // Head word is forced to zero when empty so idle output is deterministic.
   assign io_out_bits  = io_out_valid ? mem_q[rptr_q] : '0;

   assign in_fire  = io_in_valid && in_ready_q;
   assign out_fire = io_out_valid && io_out_ready;

   // Next-state for pointers, occupancy and the registered ready flag.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      if (in_fire) begin
         mem_d[wptr_q] = io_in_bits;
         wptr_d        = wptr_q + AW'(1);
      end
      if (out_fire) rptr_d = rptr_q + AW'(1);
      if (in_fire && !out_fire)      count_d = count_q + CW'(1);
      else if (!in_fire && out_fire) count_d = count_q - CW'(1);
      // Ready is a flop computed from next occupancy: no path from io_out_ready.
      in_ready_d = (count_d != FULL_CNT);
   end

   // Queue state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // ---------------------------------------------------------------
   // Perf-counter chain: request decode and counter select
   // ---------------------------------------------------------------
   logic        pc_match;
   logic        sel_ok;
   logic [15:0] sel_val;
   logic [15:0] occ16;
   logic [15:0] cnt_q [4];
   logic [15:0] cnt_d [4];
   logic [3:0]  cnt_inc;
   logic [3:0]  cnt_clr;

   assign pc_match = io_pcIn_valid && io_pcIn_bits_request &&
                     (io_pcIn_bits_moduleId == MID);
   assign occ16    = 16'(count_q);

   // Pick the addressed counter; unknown port/type answers 0xFFFF.
   always_comb begin
      sel_ok  = 1'b1;
      sel_val = 16'hFFFF;
      cnt_clr = '0;
      if (io_pcIn_bits_pcType == 4'd2 &&
          (io_pcIn_bits_portId == 8'd0 || io_pcIn_bits_portId == 8'd1)) begin
         sel_val = occ16;
      end else if (io_pcIn_bits_portId == 8'd0 && io_pcIn_bits_pcType == 4'd0) begin
         sel_val            = cnt_q[C_IN_XFER];
         cnt_clr[C_IN_XFER] = 1'b1;
      end else if (io_pcIn_bits_portId == 8'd0 && io_pcIn_bits_pcType == 4'd1) begin
         sel_val             = cnt_q[C_IN_STALL];
         cnt_clr[C_IN_STALL] = 1'b1;
      end else if (io_pcIn_bits_portId == 8'd1 && io_pcIn_bits_pcType == 4'd0) begin
         sel_val             = cnt_q[C_OUT_XFER];
         cnt_clr[C_OUT_XFER] = 1'b1;
      end else if (io_pcIn_bits_portId == 8'd1 && io_pcIn_bits_pcType == 4'd1) begin
         sel_val              = cnt_q[C_OUT_STALL];
         cnt_clr[C_OUT_STALL] = 1'b1;
      end else begin
         sel_ok = 1'b0;
      end
`ifdef OFFLOAD_IQ_CLEAR_ON_READ_EN
      // Only a real matched read of an XFER/STALL counter clears it.
      if (!pc_match || !sel_ok) cnt_clr = '0;
`else
      cnt_clr = '0;
`endif
   end

   // ---------------------------------------------------------------
   // Saturating event counters
   // ---------------------------------------------------------------
   assign cnt_inc[C_IN_XFER]   = in_fire;
   assign cnt_inc[C_IN_STALL]  = io_in_valid && !in_ready_q;
   assign cnt_inc[C_OUT_XFER]  = out_fire;
   assign cnt_inc[C_OUT_STALL] = io_out_valid && !io_out_ready;

   // Clear (if any) happens first, then the same-cycle increment lands on top.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr[i]) cnt_d[i] = '0;
         if (cnt_inc[i] && cnt_d[i] != 16'hFFFF) cnt_d[i] = cnt_d[i] + 16'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // ---------------------------------------------------------------
   // Chain output stage
   // ---------------------------------------------------------------
   logic        pc_valid_q, pc_valid_d;
   logic        pc_req_q,   pc_req_d;
   logic [15:0] pc_id_q,    pc_id_d;
   logic [7:0]  pc_port_q,  pc_port_d;
   logic [15:0] pc_val_q,   pc_val_d;
   logic [3:0]  pc_type_q,  pc_type_d;

   // Forward every beat; a matched request turns into a response in place.
   always_comb begin
      pc_valid_d = io_pcIn_valid;
      pc_req_d   = io_pcIn_bits_request;
      pc_id_d    = io_pcIn_bits_moduleId;
      pc_port_d  = io_pcIn_bits_portId;
      pc_val_d   = io_pcIn_bits_pcValue;
      pc_type_d  = io_pcIn_bits_pcType;
      if (pc_match) begin
         pc_req_d = 1'b0;
         pc_val_d = sel_val;
      end
   end

   // Chain register stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_valid_q <= 1'b0;
         pc_req_q   <= 1'b0;
         pc_id_q    <= '0;
         pc_port_q  <= '0;
         pc_val_q   <= '0;
         pc_type_q  <= '0;
      end else begin
         pc_valid_q <= pc_valid_d;
         pc_req_q   <= pc_req_d;
         pc_id_q    <= pc_id_d;
         pc_port_q  <= pc_port_d;
         pc_val_q   <= pc_val_d;
         pc_type_q  <= pc_type_d;
      end
   end

   assign io_pcOut_valid         = pc_valid_q;
   assign io_pcOut_bits_request  = pc_req_q;
   assign io_pcOut_bits_moduleId = pc_id_q;
   assign io_pcOut_bits_portId   = pc_port_q;
   assign io_pcOut_bits_pcValue  = pc_val_q;
   assign io_pcOut_bits_pcType   = pc_type_q;

endmodule

// File: tb/tb_offload_ingress_queue.sv
// Directed bench for offload_ingress_queue (WIDTH=32, DEPTH=4, MODULE_ID=1).
module tb_offload_ingress_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_bits, out_bits;
   logic        pci_valid, pci_req, pco_valid, pco_req;
   logic [15:0] pci_id, pci_val, pco_id, pco_val;
   logic [7:0]  pci_port, pco_port;
   logic [3:0]  pci_type, pco_type;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   offload_ingress_queue #(.WIDTH(32), .DEPTH(4), .MODULE_ID(1)) dut (
      .clk(clk), .reset(reset),
      .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_bits(in_bits),
      .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_bits(out_bits),
      .io_pcIn_valid(pci_valid), .io_pcIn_bits_request(pci_req),
      .io_pcIn_bits_moduleId(pci_id), .io_pcIn_bits_portId(pci_port),
      .io_pcIn_bits_pcValue(pci_val), .io_pcIn_bits_pcType(pci_type),
      .io_pcOut_valid(pco_valid), .io_pcOut_bits_request(pco_req),
      .io_pcOut_bits_moduleId(pco_id), .io_pcOut_bits_portId(pco_port),
      .io_pcOut_bits_pcValue(pco_val), .io_pcOut_bits_pcType(pco_type)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One chain beat for one cycle; result is visible on pcOut on return.
   task automatic pc_beat(input logic req, input logic [15:0] id, input logic [7:0] port,
                          input logic [15:0] val, input logic [3:0] typ);
      pci_valid = 1'b1; pci_req = req; pci_id = id;
      pci_port = port;  pci_val = val; pci_type = typ;
      step();
      pci_valid = 1'b0; pci_req = 1'b0;
   endtask

   task automatic push(input logic [31:0] d);
      in_valid = 1'b1; in_bits = d;
      step();
      in_valid = 1'b0;
   endtask

   logic [31:0] exp3 [10];
   int          k;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 0; in_bits = 0; out_ready = 0;
      pci_valid = 0; pci_req = 0; pci_id = 0; pci_port = 0; pci_val = 0; pci_type = 0;
      step(); step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_bits",  out_bits, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("rst_pco_valid", {31'd0, pco_valid}, 32'd0);
      chk("rst_pco_val",   {16'd0, pco_val}, 32'd0);
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1: three pushes with downstream blocked, then drain
      push(32'h11);
      chk("t1_valid_rise", {31'd0, out_valid}, 32'd1);
      chk("t1_head",       out_bits, 32'h11);
      push(32'h22);
      push(32'h33);
      chk("t1_hold", out_bits, 32'h11);
      out_ready = 1'b1;
      chk("t1_pop0", out_bits, 32'h11); step();
      chk("t1_pop1", out_bits, 32'h22); step();
      chk("t1_pop2", out_bits, 32'h33); step();
      chk("t1_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // 2: fill, blocked pushes, stall counts, pop frees a slot
      push(32'hA0); push(32'hA1); push(32'hA2);
      chk("t2_ready_3", {31'd0, in_ready}, 32'd1);
      push(32'hA3);
      chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; in_bits = 32'hA4;
      step(); step(); step();
      in_valid = 1'b0;
      pc_beat(1'b1, 16'd1, 8'd0, 16'h0, 4'd1);
      chk("t2_in_stall_v",  {31'd0, pco_valid}, 32'd1);
      chk("t2_in_stall_rq", {31'd0, pco_req}, 32'd0);
      chk("t2_in_stall_id", {16'd0, pco_id}, 32'd1);
      chk("t2_in_stall_ty", {28'd0, pco_type}, 32'd1);
      chk("t2_in_stall",    {16'd0, pco_val}, 32'd3);
      pc_beat(1'b1, 16'd1, 8'd0, 16'h0, 4'd2);
      chk("t2_occ_full", {16'd0, pco_val}, 32'd4);
      pc_beat(1'b1, 16'd1, 8'd1, 16'h0, 4'd1);
      chk("t2_out_stall", {16'd0, pco_val}, 32'd10);
      chk("t2_pco_drop", {31'd0, pco_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t2_pco_gone", {31'd0, pco_valid}, 32'd0);
      chk("t2_ready_after_pop", {31'd0, in_ready}, 32'd1);

      // 3: refill, then stream with both sides active for 10 cycles
      push(32'hA4);
      chk("t3_full", {31'd0, in_ready}, 32'd0);
      exp3 = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB0,
               32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
      k = 0;
      in_valid = 1'b1; out_ready = 1'b1; in_bits = 32'hB0;
      for (int i = 0; i < 10; i++) begin
         logic acc;
         chk($sformatf("t3_out%0d", i), out_bits, exp3[i]);
         acc = in_ready;
         step();
         if (acc) k++;
         in_bits = 32'hB0 + 32'(k);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t3_pushed", 32'(k), 32'd9);
      pc_beat(1'b1, 16'd1, 8'd1, 16'h0, 4'd2);
      chk("t3_occ", {16'd0, pco_val}, 32'd3);
      pc_beat(1'b1, 16'd1, 8'd1, 16'h0, 4'd3);
      chk("t3_bad_type", {16'd0, pco_val}, 32'hFFFF);
      pc_beat(1'b1, 16'd1, 8'd2, 16'h0, 4'd0);
      chk("t3_bad_port", {16'd0, pco_val}, 32'hFFFF);
      chk("t3_bad_port_rq", {31'd0, pco_req}, 32'd0);
      chk("t3_head_b6", out_bits, 32'hB6);

      // 5: reset with 3 queued and a chain beat in flight
      pci_valid = 1'b1; pci_req = 1'b0; pci_id = 16'd9;
      reset = 1'b1;
      step();
      reset = 1'b0; pci_valid = 1'b0;
      chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("t5_pco_lost",  {31'd0, pco_valid}, 32'd0);
      pc_beat(1'b1, 16'd1, 8'd0, 16'h0, 4'd0);
      chk("t5_in_xfer0", {16'd0, pco_val}, 32'd0);
      chk("t5_in_ready1", {31'd0, in_ready}, 32'd1);
      pc_beat(1'b1, 16'd1, 8'd1, 16'h0, 4'd1);
      chk("t5_out_stall0", {16'd0, pco_val}, 32'd0);
      push(32'hC1); push(32'hC2);
      chk("t5_first", out_bits, 32'hC1);

      // 4: five pops total, then read OUT_XFER; foreign id passes through
      out_ready = 1'b1;
      chk("t4_pop_c1", out_bits, 32'hC1); step();
      chk("t4_pop_c2", out_bits, 32'hC2); step();
      out_ready = 1'b0;
      push(32'hC3); push(32'hC4); push(32'hC5);
      out_ready = 1'b1;
      chk("t4_pop_c3", out_bits, 32'hC3); step();
      chk("t4_pop_c4", out_bits, 32'hC4); step();
      chk("t4_pop_c5", out_bits, 32'hC5); step();
      out_ready = 1'b0;
      pc_beat(1'b1, 16'd1, 8'd1, 16'h0, 4'd0);
      chk("t4_out_xfer", {16'd0, pco_val}, 32'd5);
      chk("t4_out_xfer_rq", {31'd0, pco_req}, 32'd0);
      chk("t4_out_xfer_pt", {24'd0, pco_port}, 32'd1);
      pc_beat(1'b1, 16'd7, 8'd1, 16'h1234, 4'd0);
      chk("t4_fwd_valid", {31'd0, pco_valid}, 32'd1);
      chk("t4_fwd_req", {31'd0, pco_req}, 32'd1);
      chk("t4_fwd_id",  {16'd0, pco_id}, 32'd7);
      chk("t4_fwd_val", {16'd0, pco_val}, 32'h1234);
      pc_beat(1'b0, 16'd1, 8'd0, 16'hBEEF, 4'd1);
      chk("t4_resp_val", {16'd0, pco_val}, 32'hBEEF);
      chk("t4_resp_ty",  {28'd0, pco_type}, 32'd1);

      // 6: second OUT_XFER read without traffic
      pc_beat(1'b1, 16'd1, 8'd1, 16'h0, 4'd0);
`ifdef OFFLOAD_IQ_CLEAR_ON_READ_EN
      chk("t6_reread", {16'd0, pco_val}, 32'd0);
`else
      chk("t6_reread", {16'd0, pco_val}, 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
